mb_fetcher: RTL and testbench

MB_FETCHER -- requirements
Module: mb_fetcher

---
 rtl/mb_fetcher_if.sv | 33 +++
 rtl/mb_fetcher.sv | 200 ++++++++++++++++++++
 tb/tb_mb_fetcher.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mb_fetcher_if.sv
// Request/response bundle of the macroblock fetcher: fetch control, frame-memory
// read port and the outgoing pixel stream.
interface mb_fetcher_if #(
  parameter int PIXEL_W = 8,
  parameter int ADDR_W  = 20,
  parameter int MBN_W   = 13
);
  logic               start;
  logic [MBN_W-1:0]   mbnumber;
  logic               busy;
  logic               done;
  logic               err;
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [PIXEL_W-1:0] mem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [PIXEL_W-1:0] out_data;
  logic [1:0]         out_kind;
  logic               out_last;

  // fetcher side
  modport master (
    input  start, mbnumber, mem_rdata, out_ready,
    output busy, done, err, mem_rd, mem_addr, out_valid, out_data, out_kind, out_last
  );

  // requester / memory / stream-consumer side
  modport slave (
    output start, mbnumber, mem_rdata, out_ready,
    input  busy, done, err, mem_rd, mem_addr, out_valid, out_data, out_kind, out_last
  );
endinterface

// File: rtl/mb_fetcher.sv
// Fetches one macroblock plus its corner/top/left neighbours from the
// reconstructed frame and streams them out, substituting mid-grey off-frame.
module mb_fetcher #(
  parameter int PIXEL_W   = 8,
  parameter int FRAME_W   = 1280,
  parameter int FRAME_H   = 720,
  parameter int MB_W      = 16,
  parameter int MB_H      = 16,
  parameter int TOP_RIGHT = 0,
  parameter int ADDR_W    = 20,
  parameter int MBN_W     = 13
) (
  input  logic         clk,
  input  logic         reset,
  mb_fetcher_if.master bus
);

  localparam int          BPR   = FRAME_W / MB_W;
  localparam int unsigned NMB   = BPR * (FRAME_H / MB_H);
  localparam int          TOPN  = MB_W * (1 + TOP_RIGHT);
  localparam int          CNT_W = 6;

  localparam logic [PIXEL_W-1:0] MID   = {1'b1, {(PIXEL_W-1){1'b0}}};
  localparam logic [MBN_W-1:0]   BPR_M = MBN_W'(BPR);
  localparam logic [ADDR_W-1:0]  ONE_A = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  FW_A  = ADDR_W'(FRAME_W);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_EMIT} state_t;
  typedef enum logic [1:0] {K_CORNER, K_TOP, K_LEFT, K_BLOCK} kind_t;

  state_t             state, nstate;
  kind_t              kind_r, nd_kind;
  logic [CNT_W-1:0]   ci, rj, nd_ci, nd_rj;
  logic [ADDR_W-1:0]  x0, y0, xs, ys, n_addr, addr_r;
  logic               oor, n_subst, n_last, last_r, done_r, err_r;
  logic [PIXEL_W-1:0] data_r;
  logic               take_start, load_beat, cap, fin, fin_err;

  assign bus.busy      = (state != S_IDLE) || done_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.mem_rd    = (state == S_ISSUE);
  assign bus.mem_addr  = addr_r;
  assign bus.out_valid = (state == S_EMIT);
  assign bus.out_data  = data_r;
  assign bus.out_kind  = kind_r;
  assign bus.out_last  = last_r;

  // Descriptor of the beat about to be loaded: the corner when leaving CALC,
  // otherwise the successor of the beat currently being emitted.
  always_comb begin
    nd_kind = K_CORNER;
    nd_ci   = '0;
    nd_rj   = '0;
    if (state == S_EMIT) begin
      unique case (kind_r)
        K_CORNER: nd_kind = K_TOP;
        K_TOP: begin
          if (ci == CNT_W'(TOPN-1)) begin
            nd_kind = K_LEFT;
          end else begin
            nd_kind = K_TOP;
            nd_ci   = ci + CNT_W'(1);
          end
        end
        K_LEFT: begin
          if (rj == CNT_W'(MB_H-1)) begin
            nd_kind = K_BLOCK;
          end else begin
            nd_kind = K_LEFT;
            nd_rj   = rj + CNT_W'(1);
          end
        end
        K_BLOCK: begin
          nd_kind = K_BLOCK;
          if (ci == CNT_W'(MB_W-1)) begin
            nd_rj = rj + CNT_W'(1);
          end else begin
            nd_ci = ci + CNT_W'(1);
            nd_rj = rj;
          end
        end
      endcase
    end
  end

  // Pixel coordinates of the next beat; off-frame top/left neighbours are
  // substituted, off-frame top-right ones re-read the last top pixel.
  always_comb begin
    xs      = x0 + ADDR_W'(nd_ci);
    ys      = y0 + ADDR_W'(nd_rj);
    n_subst = 1'b0;
    n_last  = 1'b0;
    unique case (nd_kind)
      K_CORNER: begin
        xs      = x0 - ONE_A;
        ys      = y0 - ONE_A;
        n_subst = (x0 == '0) || (y0 == '0);
      end
      K_TOP: begin
        ys      = y0 - ONE_A;
        n_subst = (y0 == '0);
        if (xs >= FW_A) xs = x0 + ADDR_W'(MB_W-1);
      end
      K_LEFT: begin
        xs      = x0 - ONE_A;
        n_subst = (x0 == '0);
      end
      K_BLOCK: n_last = (nd_ci == CNT_W'(MB_W-1)) && (nd_rj == CNT_W'(MB_H-1));
    endcase
    n_addr = ys * FW_A + xs;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate     = state;
    take_start = 1'b0;
    load_beat  = 1'b0;
    cap        = 1'b0;
    fin        = 1'b0;
    fin_err    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          take_start = 1'b1;
          nstate     = S_CALC;
        end
      end
      S_CALC: begin
        if (oor) begin
          fin_err = 1'b1;
          nstate  = S_IDLE;
        end else begin
          load_beat = 1'b1;
          nstate    = n_subst ? S_EMIT : S_ISSUE;
        end
      end
      S_ISSUE: nstate = S_WAIT;
      S_WAIT: begin
        cap    = 1'b1;
        nstate = S_EMIT;
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          if (last_r) begin
            fin    = 1'b1;
            nstate = S_IDLE;
          end else begin
            load_beat = 1'b1;
            nstate    = n_subst ? S_EMIT : S_ISSUE;
          end
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x0     <= '0;
      y0     <= '0;
      oor    <= 1'b0;
      kind_r <= K_CORNER;
      ci     <= '0;
      rj     <= '0;
      data_r <= '0;
      addr_r <= '0;
      last_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (take_start) begin
        x0  <= ADDR_W'(bus.mbnumber % BPR_M) * ADDR_W'(MB_W);
        y0  <= ADDR_W'(bus.mbnumber / BPR_M) * ADDR_W'(MB_H);
        oor <= 32'(bus.mbnumber) >= NMB;
      end
      if (fin_err) begin
        done_r <= 1'b1;
        err_r  <= 1'b1;
      end
      if (fin) done_r <= 1'b1;
      if (load_beat) begin
        kind_r <= nd_kind;
        ci     <= nd_ci;
        rj     <= nd_rj;
        last_r <= n_last;
        if (n_subst) data_r <= MID;
        else         addr_r <= n_addr;
      end
      if (cap) data_r <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mb_fetcher.sv
// Directed bench for mb_fetcher on a 64x32 frame of 16x16 blocks; memory
// returns addr[7:0] one cycle after each read strobe.
module tb_mb_fetcher;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        st = 1'b0, sel = 1'b0, rdy = 1'b1;
  logic [12:0] mbn = '0;
  int          checks = 0, errors = 0;

  mb_fetcher_if #(.PIXEL_W(8), .ADDR_W(20), .MBN_W(13)) b0 ();
  mb_fetcher_if #(.PIXEL_W(8), .ADDR_W(20), .MBN_W(13)) b1 ();

  mb_fetcher #(.PIXEL_W(8), .FRAME_W(64), .FRAME_H(32), .MB_W(16), .MB_H(16),
               .TOP_RIGHT(0), .ADDR_W(20), .MBN_W(13))
    dut0 (.clk(clk), .reset(reset), .bus(b0));

  mb_fetcher #(.PIXEL_W(8), .FRAME_W(64), .FRAME_H(32), .MB_W(16), .MB_H(16),
               .TOP_RIGHT(1), .ADDR_W(20), .MBN_W(13))
    dut1 (.clk(clk), .reset(reset), .bus(b1));

  assign b0.start     = st & ~sel;
  assign b1.start     = st & sel;
  assign b0.mbnumber  = mbn;
  assign b1.mbnumber  = mbn;
  assign b0.out_ready = rdy;
  assign b1.out_ready = rdy;

  always @(posedge clk) begin
    b0.mem_rdata <= b0.mem_rd ? b0.mem_addr[7:0] : 8'hEE;
    b1.mem_rdata <= b1.mem_rd ? b1.mem_addr[7:0] : 8'hEE;
  end

  logic        m_valid, m_last, m_rd, m_done, m_err;
  logic [7:0]  m_data;
  logic [1:0]  m_kind;
  logic [19:0] m_addr;
  always_comb begin
    if (sel) {m_valid, m_last, m_rd, m_done, m_err, m_data, m_kind, m_addr} =
               {b1.out_valid, b1.out_last, b1.mem_rd, b1.done, b1.err, b1.out_data, b1.out_kind, b1.mem_addr};
    else     {m_valid, m_last, m_rd, m_done, m_err, m_data, m_kind, m_addr} =
               {b0.out_valid, b0.out_last, b0.mem_rd, b0.done, b0.err, b0.out_data, b0.out_kind, b0.mem_addr};
  end

  // Beats are recorded as {kind, last, data}; inputs only change at posedge+1.
  logic [10:0] got_q[$];
  int          addr_q[$];
  int          done_cnt = 0, err_cnt = 0, valid_cyc = 0, stall_viol = 0, rd_valid = 0;
  logic        hold = 1'b0;
  logic [10:0] hold_v = '0;

  always @(negedge clk) begin
    if (hold && (!m_valid || {m_kind, m_last, m_data} !== hold_v)) stall_viol <= stall_viol + 1;
    hold   <= m_valid && !rdy;
    hold_v <= {m_kind, m_last, m_data};
    if (m_valid)          valid_cyc <= valid_cyc + 1;
    if (m_valid && rdy)   got_q.push_back({m_kind, m_last, m_data});
    if (m_rd)             addr_q.push_back(int'(m_addr));
    if (m_rd && m_valid)  rd_valid <= rd_valid + 1;
    if (m_done)           done_cnt <= done_cnt + 1;
    if (m_err)            err_cnt <= err_cnt + 1;
  end

  logic [10:0] exp_q[$];
  int          exp_addr[$];

  function automatic logic [7:0] pix(input int x, input int y);
    if (x < 0 || y < 0) return 8'd128;
    return 8'((y * 64 + x) & 255);
  endfunction

  task automatic build_exp(input int mb, input bit tr);
    int x0, y0, x, topn;
    exp_q.delete();
    exp_addr.delete();
    x0 = (mb % 4) * 16;
    y0 = (mb / 4) * 16;
    topn = tr ? 32 : 16;
    exp_q.push_back({2'd0, 1'b0, pix(x0 - 1, y0 - 1)});
    if (x0 > 0 && y0 > 0) exp_addr.push_back((y0 - 1) * 64 + x0 - 1);
    for (int i = 0; i < topn; i++) begin
      x = x0 + i;
      if (x >= 64) x = x0 + 15;
      exp_q.push_back({2'd1, 1'b0, pix(x, y0 - 1)});
      if (y0 > 0) exp_addr.push_back((y0 - 1) * 64 + x);
    end
    for (int j = 0; j < 16; j++) begin
      exp_q.push_back({2'd2, 1'b0, pix(x0 - 1, y0 + j)});
      if (x0 > 0) exp_addr.push_back((y0 + j) * 64 + x0 - 1);
    end
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 16; i++) begin
        exp_q.push_back({2'd3, (i == 15 && j == 15), pix(x0 + i, y0 + j)});
        exp_addr.push_back((y0 + j) * 64 + x0 + i);
      end
  endtask

  task automatic clear_mon();
    got_q.delete();
    addr_q.delete();
    done_cnt = 0; err_cnt = 0; valid_cyc = 0; stall_viol = 0; rd_valid = 0;
  endtask

  task automatic run_fetch(input int mb, input int mode, output bit timeout);
    rdy = (mode == 0);
    @(posedge clk); #1;
    st = 1'b1; mbn = 13'(mb);
    @(posedge clk); #1;
    st = 1'b0;
    timeout = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if (done_cnt > 0) begin
        timeout = 1'b0;
        break;
      end
      rdy = (mode == 0) ? 1'b1 : (c % 3 == 0);
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b0.busy, b0.done, b0.err, b0.mem_rd, b0.out_valid, b0.out_last, b0.out_kind, b0.out_data, b0.mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_dut0: got busy=%b done=%b err=%b rd=%b valid=%b last=%b kind=%0d data=%0d addr=%0d, want all 0",
               b0.busy, b0.done, b0.err, b0.mem_rd, b0.out_valid, b0.out_last, b0.out_kind, b0.out_data, b0.mem_addr);
    end
    checks++;
    if ({b1.busy, b1.done, b1.err, b1.mem_rd, b1.out_valid, b1.out_last, b1.out_kind, b1.out_data, b1.mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: got busy=%b valid=%b rd=%b, want all 0", b1.busy, b1.out_valid, b1.mem_rd);
    end
    reset = 1'b0;
  endtask

  task automatic test_mb0();
    bit to;
    logic [10:0] v;
    sel = 1'b0;
    clear_mon();
    build_exp(0, 1'b0);
    run_fetch(0, 0, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL mb0_timeout: got timeout=%b want 0", to); end
    checks++;
    if (got_q.size() !== 289) begin errors++; $display("FAIL mb0_beats: got %0d want 289", got_q.size()); end
    checks++;
    if (addr_q.size() !== 256) begin errors++; $display("FAIL mb0_reads: got %0d want 256", addr_q.size()); end
    v = got_q[0];
    checks++;
    if (v !== {2'd0, 1'b0, 8'd128}) begin errors++; $display("FAIL mb0_corner: got %h want %h", v, {2'd0, 1'b0, 8'd128}); end
    v = got_q[49];
    checks++;
    if (v[7:0] !== 8'd64) begin errors++; $display("FAIL mb0_row1: got %0d want 64", v[7:0]); end
    checks++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      errors++; $display("FAIL mb0_done: got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mb0_beat %0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 0; i < exp_addr.size() && i < addr_q.size(); i++) begin
      checks++;
      if (addr_q[i] !== exp_addr[i]) begin errors++; $display("FAIL mb0_addr %0d: got %0d want %0d", i, addr_q[i], exp_addr[i]); end
    end
  endtask

  task automatic test_mb5(input int mode);
    bit to;
    sel = 1'b0;
    clear_mon();
    build_exp(5, 1'b0);
    run_fetch(5, mode, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL mb5_timeout mode%0d: got timeout=%b want 0", mode, to); end
    checks++;
    if (got_q.size() !== 289 || addr_q.size() !== 289) begin
      errors++; $display("FAIL mb5_counts mode%0d: got beats=%0d reads=%0d want 289/289", mode, got_q.size(), addr_q.size());
    end
    checks++;
    if (addr_q[0] !== 975 || addr_q[1] !== 976 || addr_q[16] !== 991 || addr_q[17] !== 1039 ||
        addr_q[18] !== 1103 || addr_q[33] !== 1040) begin
      errors++;
      $display("FAIL mb5_addrs mode%0d: got %0d %0d %0d %0d %0d %0d want 975 976 991 1039 1103 1040", mode,
               addr_q[0], addr_q[1], addr_q[16], addr_q[17], addr_q[18], addr_q[33]);
    end
    checks++;
    if (stall_viol !== 0 || rd_valid !== 0) begin
      errors++; $display("FAIL mb5_stall mode%0d: got unstable=%0d rd_while_valid=%0d want 0/0", mode, stall_viol, rd_valid);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mb5_beat %0d mode%0d: got %h want %h", i, mode, got_q[i], exp_q[i]); end
    end
    for (int i = 0; i < exp_addr.size() && i < addr_q.size(); i++) begin
      checks++;
      if (addr_q[i] !== exp_addr[i]) begin errors++; $display("FAIL mb5_addr %0d mode%0d: got %0d want %0d", i, mode, addr_q[i], exp_addr[i]); end
    end
  endtask

  task automatic test_out_of_range();
    sel = 1'b0;
    clear_mon();
    @(posedge clk); #1;
    st = 1'b1; mbn = 13'd8;
    @(posedge clk); #1;
    st = 1'b0;
    checks++;
    if ({b0.busy, b0.done, b0.err} !== 3'b100) begin
      errors++; $display("FAIL oor_calc: got busy/done/err=%b want 100", {b0.busy, b0.done, b0.err});
    end
    @(posedge clk); #1;
    checks++;
    if ({b0.busy, b0.done, b0.err} !== 3'b111) begin
      errors++; $display("FAIL oor_done: got busy/done/err=%b want 111", {b0.busy, b0.done, b0.err});
    end
    @(posedge clk); #1;
    checks++;
    if ({b0.busy, b0.done, b0.err} !== 3'b000) begin
      errors++; $display("FAIL oor_after: got busy/done/err=%b want 000", {b0.busy, b0.done, b0.err});
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (addr_q.size() !== 0 || valid_cyc !== 0) begin
      errors++; $display("FAIL oor_quiet: got reads=%0d valid_cycles=%0d want 0/0", addr_q.size(), valid_cyc);
    end
  endtask

  task automatic test_top_right();
    bit to;
    logic [10:0] v;
    sel = 1'b1;
    clear_mon();
    build_exp(7, 1'b1);
    run_fetch(7, 0, to);
    checks++;
    if (to !== 1'b0 || got_q.size() !== 305 || addr_q.size() !== 305) begin
      errors++; $display("FAIL tr_counts: got timeout=%b beats=%0d reads=%0d want 0/305/305", to, got_q.size(), addr_q.size());
    end
    v = got_q[17];
    checks++;
    if (v !== {2'd1, 1'b0, 8'd255}) begin errors++; $display("FAIL tr_first_ext: got %h want %h", v, {2'd1, 1'b0, 8'd255}); end
    checks++;
    if (addr_q[32] !== 1023) begin errors++; $display("FAIL tr_last_ext_addr: got %0d want 1023", addr_q[32]); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL tr_beat %0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    bit to;
    bit reached;
    sel = 1'b0;
    clear_mon();
    rdy = 1'b1;
    @(posedge clk); #1;
    st = 1'b1; mbn = 13'd0;
    @(posedge clk); #1;
    st = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (got_q.size() >= 100) begin
        reached = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (reached !== 1'b1) begin errors++; $display("FAIL midreset_reach: got %0d beats want 100", got_q.size()); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({b0.busy, b0.done, b0.err, b0.mem_rd, b0.out_valid, b0.out_last, b0.out_kind, b0.out_data, b0.mem_addr} !== '0) begin
      errors++;
      $display("FAIL midreset_zero: got busy=%b valid=%b rd=%b data=%0d addr=%0d kind=%0d, want all 0",
               b0.busy, b0.out_valid, b0.mem_rd, b0.out_data, b0.mem_addr, b0.out_kind);
    end
    reset = 1'b0;
    clear_mon();
    build_exp(0, 1'b0);
    run_fetch(0, 0, to);
    checks++;
    if (to !== 1'b0 || got_q.size() !== 289) begin
      errors++; $display("FAIL midreset_refetch: got timeout=%b beats=%0d want 0/289", to, got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_beat %0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    sel = 1'b0;
    clear_mon();
    rdy = 1'b1;
    @(posedge clk); #1;
    st = 1'b1; mbn = 13'd5;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    st = 1'b1; mbn = 13'd8;
    @(posedge clk); #1;
    st = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (b0.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b1 || err_cnt !== 0 || got_q.size() !== 289) begin
      errors++; $display("FAIL b2b_first: got done_seen=%b errs=%0d beats=%0d want 1/0/289", seen, err_cnt, got_q.size());
    end
    st = 1'b1; mbn = 13'd8;
    @(posedge clk); #1;
    st = 1'b0;
    checks++;
    if ({b0.busy, b0.done} !== 2'b10) begin
      errors++; $display("FAIL b2b_accept: got busy/done=%b want 10", {b0.busy, b0.done});
    end
    @(posedge clk); #1;
    checks++;
    if ({b0.done, b0.err} !== 2'b11) begin
      errors++; $display("FAIL b2b_err: got done/err=%b want 11", {b0.done, b0.err});
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_mb0();
    test_mb5(0);
    test_out_of_range();
    test_mb5(1);
    test_top_right();
    test_reset_midfetch();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
